reg_file_2r1w: RTL and testbench
================================

Name: reg_file_2r1w

Overview:
Parametrised two-read, one-write synchronous register file for the datapath. Successor to the single-port B-bit x 2**Add array, with these additions:
- two independent registered read ports;
- reads that proceed concurrently with writes;
- selectable read-during-write bypass;
- a hardware clear sequencer that zeroes the array after reset or on request.
It sits between the ALU/control path and the operand registers.

Parameters:
B, 8, word width in bits
Add, 4, address bits; depth = 2**Add
BYPASS, 1, 1 = read-during-write to same address returns new w_data; 0 = returns old contents

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
clr  in  1  one-cycle request to zero the whole array (honoured only when busy=0)
wr_en  in  1  write enable
w_addr  in  Add  write address
w_data  in  B  write data
rd_en_a  in  1  port A read enable
r_addr_a  in  Add  port A read address
r_data_a  out  B  port A registered read data
r_valid_a  out  1  port A data valid
rd_en_b  in  1  port B read enable
r_addr_b  in  Add  port B read address
r_data_b  out  B  port B registered read data
r_valid_b  out  1  port B data valid
busy  out  1  clear sequence in progress

Behaviour:
Reset (reset=1 at an edge):
- r_data_a, r_data_b <= 0; r_valid_a, r_valid_b <= 0; busy <= 1.
- FSM <= CLEAR; clear counter cnt <= 0.
- While reset is held, cnt stays at 0 and no array location is written.
- Reset asserted mid-clear restarts the sequence from address 0.

FSM has two states, CLEAR and RUN:
- CLEAR, each edge with reset=0: mem[cnt] <= 0; cnt <= cnt+1.
- When cnt == 2**Add-1, that edge writes the last location and moves to RUN; busy <= 0.
- A full clear therefore takes exactly 2**Add edges after reset is released. busy is 1 throughout and falls at the edge that clears the last address.
- RUN: clr=1 at an edge moves to CLEAR with cnt <= 0 and busy <= 1. That edge performs no user write. Clearing of address 0 starts on the next edge.
- clr while busy=1 is ignored; the sequence is not restarted.

In CLEAR:
- wr_en is ignored.
- rd_en_a/b are ignored: r_valid_a/b <= 0 and r_data_a/b hold their values.

Write (RUN):
- wr_en=1 at an edge: mem[w_addr] <= w_data. Single-cycle, no handshake.

Read (RUN, per port, ports independent):
- rd_en=1 at edge n: r_data <= mem[r_addr] and r_valid <= 1. Data is visible after edge n; latency is 1 cycle.
- rd_en=0: r_valid <= 0 and r_data holds its last value.
- Reads are never blocked by writes.

Read-during-write (RUN, wr_en=1, rd_en=1, r_addr == w_addr at the same edge):
- BYPASS=1: r_data <= w_data.
- BYPASS=0: r_data <= the pre-write contents.
- Each port evaluates this independently. Both ports may read the same address in the same cycle and receive identical data.

Other rules:
- All addresses are in range by construction (depth = 2**Add); there is no wrap or overflow condition.
- cnt is Add+1 bits wide, or terminal detection is done on the all-ones value, so the counter never wraps into a second pass.
- Implementation uses a 2**Add x B reg array, one FSM, one counter, and per-port output registers. No combinational read path to the outputs.

Test Plan (B=8, Add=4, depth 16):
1. Reset for 2 cycles, then release -> busy=1 for exactly 16 edges then falls to 0. Reading all 16 addresses afterwards returns 0x00 with r_valid=1 one cycle after each rd_en.
2. After clear: write 0xFF@0, 0xFE@1, 0x64@2; then read port A addr 0 and port B addr 2 in the same cycle -> next cycle r_data_a=0xFF, r_data_b=0x64, both valid=1. Following cycle with rd_en=0 -> valid=0, data held.
3. mem[5]=0x11; same edge wr_en=1, w_addr=5, w_data=0x22, rd_en_a=1, r_addr_a=5 -> r_data_a=0x22 with BYPASS=1, 0x11 with BYPASS=0. A port-B read of 5 on the next cycle returns 0x22 in both modes.
4. Fill addresses 0..15 with 0xA0+i, pulse clr -> busy=1 for 16 cycles. During that time, writes of 0x55 and reads give r_valid=0 and no array change. After busy=0, every address reads 0x00.
5. During a clear, assert reset at clear cycle 7 for 1 cycle -> busy stays 1 and the clear restarts from address 0, ending 16 edges after reset release. A second clr pulse mid-sequence does not extend it.
6. Back-to-back: write addr 3 = 0x3C at cycle k and read addr 3 on port B at cycle k+1 -> r_data_b=0x3C after edge k+1 (BYPASS=0 and 1 alike).

Source files
------------

// File: rtl/reg_file_2r1w.sv
// Two-read, one-write synchronous register file with registered read ports,
// optional read-during-write bypass and a hardware clear sequencer.
module reg_file_2r1w #(
    parameter int B      = 8,
    parameter int Add    = 4,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clr,
    input  logic           wr_en,
    input  logic [Add-1:0] w_addr,
    input  logic [B-1:0]   w_data,
    input  logic           rd_en_a,
    input  logic [Add-1:0] r_addr_a,
    output logic [B-1:0]   r_data_a,
    output logic           r_valid_a,
    input  logic           rd_en_b,
    input  logic [Add-1:0] r_addr_b,
    output logic [B-1:0]   r_data_b,
    output logic           r_valid_b,
    output logic           busy
);

    localparam int             DEPTH = 2 ** Add;
    localparam logic [Add-1:0] LAST  = {Add{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t         state_r, state_s;
    logic [Add-1:0] cnt_r, cnt_s;
    logic           busy_r, busy_s;

    logic           mem_we_s;
    logic           user_wr_s;
    logic [Add-1:0] mem_addr_s;
    logic [B-1:0]   mem_data_s;
    logic [B-1:0]   mem_r [DEPTH];

    logic           upd_a_s, upd_b_s;
    logic [B-1:0]   rd_a_s, rd_b_s;
    logic [B-1:0]   r_data_a_r, r_data_b_r;
    logic           r_valid_a_r, r_valid_b_r;

    // Clear sequencer next state and the single array write port selection.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        busy_s     = busy_r;
        mem_we_s   = 1'b0;
        user_wr_s  = 1'b0;
        mem_addr_s = cnt_r;
        mem_data_s = {B{1'b0}};
        case (state_r)
            CLEAR: begin
                mem_we_s   = 1'b1;
                mem_addr_s = cnt_r;
                mem_data_s = {B{1'b0}};
                // Terminal detect on all-ones so the counter never starts a second pass.
                if (cnt_r == LAST) begin
                    state_s = RUN;
                    cnt_s   = {Add{1'b0}};
                    busy_s  = 1'b0;
                end else begin
                    cnt_s  = cnt_r + Add'(1);
                    busy_s = 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_s = CLEAR;
                    cnt_s   = {Add{1'b0}};
                    busy_s  = 1'b1;
                end else if (wr_en) begin
                    busy_s     = 1'b0;
                    mem_we_s   = 1'b1;
                    user_wr_s  = 1'b1;
                    mem_addr_s = w_addr;
                    mem_data_s = w_data;
                end else begin
                    busy_s = 1'b0;
                end
            end
            default: begin
                state_s = CLEAR;
                cnt_s   = {Add{1'b0}};
                busy_s  = 1'b1;
            end
        endcase
    end

    // Sequencer state, clear counter and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= CLEAR;
            cnt_r   <= {Add{1'b0}};
            busy_r  <= 1'b1;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            busy_r  <= busy_s;
        end
    end

    // Storage array; nothing is written while reset is held.
    always_ff @(posedge clk) begin
        if (!reset && mem_we_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
    end

    // Per-port read data selection, including same-address write forwarding.
    always_comb begin
        upd_a_s = (state_r == RUN) && rd_en_a;
        upd_b_s = (state_r == RUN) && rd_en_b;
        if ((BYPASS == 1'b1) && user_wr_s && (w_addr == r_addr_a)) begin
            rd_a_s = w_data;
        end else begin
            rd_a_s = mem_r[r_addr_a];
        end
        if ((BYPASS == 1'b1) && user_wr_s && (w_addr == r_addr_b)) begin
            rd_b_s = w_data;
        end else begin
            rd_b_s = mem_r[r_addr_b];
        end
    end

    // Registered read ports; data holds whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_a_r  <= {B{1'b0}};
            r_data_b_r  <= {B{1'b0}};
            r_valid_a_r <= 1'b0;
            r_valid_b_r <= 1'b0;
        end else begin
            r_valid_a_r <= upd_a_s;
            r_valid_b_r <= upd_b_s;
            if (upd_a_s) begin
                r_data_a_r <= rd_a_s;
            end
            if (upd_b_s) begin
                r_data_b_r <= rd_b_s;
            end
        end
    end

    assign r_data_a  = r_data_a_r;
    assign r_data_b  = r_data_b_r;
    assign r_valid_a = r_valid_a_r;
    assign r_valid_b = r_valid_b_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: one instance per bypass mode, driven in
// lockstep, checked against hand-computed vectors and clear-sequence timing.
module tb_reg_file_2r1w;

    logic       clk, reset, clr, wr_en, rd_en_a, rd_en_b;
    logic [3:0] w_addr, r_addr_a, r_addr_b;
    logic [7:0] w_data;
    logic [7:0] r_data_a1, r_data_b1, r_data_a0, r_data_b0;
    logic       r_valid_a1, r_valid_b1, r_valid_a0, r_valid_b0;
    logic       busy1, busy0;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file_2r1w #(.B(8), .Add(4), .BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .rd_en_a(rd_en_a), .r_addr_a(r_addr_a), .r_data_a(r_data_a1), .r_valid_a(r_valid_a1),
        .rd_en_b(rd_en_b), .r_addr_b(r_addr_b), .r_data_b(r_data_b1), .r_valid_b(r_valid_b1),
        .busy(busy1)
    );

    reg_file_2r1w #(.B(8), .Add(4), .BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .clr(clr),
        .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
        .rd_en_a(rd_en_a), .r_addr_a(r_addr_a), .r_data_a(r_data_a0), .r_valid_a(r_valid_a0),
        .rd_en_b(rd_en_b), .r_addr_b(r_addr_b), .r_data_b(r_data_b0), .r_valid_b(r_valid_b0),
        .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic       ea;
        logic [3:0] ra;
        logic       eb;
        logic [3:0] rb;
        logic       va;
        logic [7:0] da1;
        logic [7:0] da0;
        logic       vb;
        logic [7:0] db1;
        logic [7:0] db0;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                                input logic ea, input logic [3:0] ra,
                                input logic eb, input logic [3:0] rb,
                                input logic va, input logic [7:0] da1, input logic [7:0] da0,
                                input logic vb, input logic [7:0] db1, input logic [7:0] db0);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.ea = ea; v.ra = ra; v.eb = eb; v.rb = rb;
        v.va = va; v.da1 = da1; v.da0 = da0; v.vb = vb; v.db1 = db1; v.db0 = db0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 1'b0; wr_en = 1'b0; w_addr = 4'd0; w_data = 8'h00;
        rd_en_a = 1'b0; r_addr_a = 4'd0; rd_en_b = 1'b0; r_addr_b = 4'd0;
    endtask

    task automatic check_outs(input string name, input logic va, input logic [7:0] da1,
                              input logic [7:0] da0, input logic vb, input logic [7:0] db1,
                              input logic [7:0] db0);
        chk({name, "_va1"}, 32'(r_valid_a1), 32'(va));
        chk({name, "_va0"}, 32'(r_valid_a0), 32'(va));
        chk({name, "_da1"}, 32'(r_data_a1), 32'(da1));
        chk({name, "_da0"}, 32'(r_data_a0), 32'(da0));
        chk({name, "_vb1"}, 32'(r_valid_b1), 32'(vb));
        chk({name, "_vb0"}, 32'(r_valid_b0), 32'(vb));
        chk({name, "_db1"}, 32'(r_data_b1), 32'(db1));
        chk({name, "_db0"}, 32'(r_data_b0), 32'(db0));
    endtask

    task automatic check_busy(input string name, input logic exp);
        chk({name, "_busy1"}, 32'(busy1), 32'(exp));
        chk({name, "_busy0"}, 32'(busy0), 32'(exp));
    endtask

    task automatic write_word(input logic [3:0] a, input logic [7:0] d);
        idle();
        wr_en = 1'b1; w_addr = a; w_data = d;
        step();
        idle();
    endtask

    task automatic read_all_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            idle();
            rd_en_a = 1'b1; r_addr_a = 4'(i);
            rd_en_b = 1'b1; r_addr_b = 4'(15 - i);
            step();
            check_outs($sformatf("%s_rd%0d", name, i), 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00);
        end
        idle();
    endtask

    // Runs a clear of 'edges' edges; busy must stay high until the last one.
    task automatic clear_loop(input string name, input int edges, input int clr_at,
                              input bit poke, input logic [7:0] ha, input logic [7:0] hb);
        for (int n = 1; n <= edges; n++) begin
            idle();
            clr = (n == clr_at);
            if (poke) begin
                wr_en = 1'b1; w_addr = 4'd0; w_data = 8'h55;
                rd_en_a = 1'b1; r_addr_a = 4'(n);
                rd_en_b = 1'b1; r_addr_b = 4'd0;
            end
            step();
            check_busy($sformatf("%s_e%0d", name, n), n < edges);
            check_outs($sformatf("%s_e%0d", name, n), 1'b0, ha, ha, 1'b0, hb, hb);
        end
        idle();
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 4'd0, 8'hFF, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[1]  = mk(1'b1, 4'd1, 8'hFE, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[2]  = mk(1'b1, 4'd2, 8'h64, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        vecs[3]  = mk(1'b0, 4'd0, 8'h00, 1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 8'hFF, 8'hFF, 1'b1, 8'h64, 8'h64);
        vecs[4]  = mk(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h64, 8'h64);
        vecs[5]  = mk(1'b1, 4'd5, 8'h11, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h64, 8'h64);
        vecs[6]  = mk(1'b1, 4'd5, 8'h22, 1'b1, 4'd5, 1'b0, 4'd0, 1'b1, 8'h22, 8'h11, 1'b0, 8'h64, 8'h64);
        vecs[7]  = mk(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 4'd5, 1'b0, 8'h22, 8'h11, 1'b1, 8'h22, 8'h22);
        vecs[8]  = mk(1'b1, 4'd3, 8'h3C, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h22, 8'h11, 1'b0, 8'h22, 8'h22);
        vecs[9]  = mk(1'b0, 4'd0, 8'h00, 1'b0, 4'd0, 1'b1, 4'd3, 1'b0, 8'h22, 8'h11, 1'b1, 8'h3C, 8'h3C);
        vecs[10] = mk(1'b1, 4'd2, 8'h77, 1'b1, 4'd2, 1'b1, 4'd2, 1'b1, 8'h77, 8'h64, 1'b1, 8'h77, 8'h64);
        vecs[11] = mk(1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 1'b1, 4'd1, 1'b1, 8'h77, 8'h77, 1'b1, 8'hFE, 8'hFE);

        idle();
        reset = 1'b1;
        step();
        step();
        check_busy("rst", 1'b1);
        check_outs("rst", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        reset = 1'b0;

        // Power-up clear: exactly 16 edges of busy, then everything reads zero.
        clear_loop("init_clr", 16, -1, 1'b0, 8'h00, 8'h00);
        read_all_zero("init");

        // Writes, dual reads, bypass and back-to-back cases.
        for (int i = 0; i < 12; i++) begin
            idle();
            wr_en = vecs[i].we; w_addr = vecs[i].wa; w_data = vecs[i].wd;
            rd_en_a = vecs[i].ea; r_addr_a = vecs[i].ra;
            rd_en_b = vecs[i].eb; r_addr_b = vecs[i].rb;
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].va, vecs[i].da1, vecs[i].da0,
                       vecs[i].vb, vecs[i].db1, vecs[i].db0);
        end
        idle();

        // Requested clear over a filled array, with writes and reads poked in.
        for (int i = 0; i < 16; i++) begin
            write_word(4'(i), 8'hA0 + 8'(i));
        end
        rd_en_a = 1'b1; r_addr_a = 4'd7; rd_en_b = 1'b1; r_addr_b = 4'd15;
        step();
        check_outs("fill", 1'b1, 8'hA7, 8'hA7, 1'b1, 8'hAF, 8'hAF);
        idle();
        clr = 1'b1;
        step();
        check_busy("clr_edge", 1'b1);
        clear_loop("req_clr", 16, -1, 1'b1, 8'hA7, 8'hAF);
        read_all_zero("req");

        // Reset in the middle of a clear restarts it; a second clr is ignored.
        write_word(4'd0, 8'h99);
        write_word(4'd15, 8'h99);
        rd_en_a = 1'b1; r_addr_a = 4'd0; rd_en_b = 1'b1; r_addr_b = 4'd15;
        step();
        check_outs("pre5", 1'b1, 8'h99, 8'h99, 1'b1, 8'h99, 8'h99);
        idle();
        clr = 1'b1;
        step();
        idle();
        for (int n = 0; n < 7; n++) begin
            step();
            check_busy($sformatf("mid_e%0d", n), 1'b1);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_busy("mid_rst", 1'b1);
        check_outs("mid_rst", 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        clear_loop("restart", 16, 5, 1'b0, 8'h00, 8'h00);
        step();
        check_busy("after", 1'b0);
        read_all_zero("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
